// File: rtl/word_serializer_if.sv
// word_serializer_if
//   Bundles the two handshakes of word_serializer: the parallel word input
//   (in_valid / in_ready / in) and the serial bit output
//   (out_valid / out_ready / out / out_last).
//   master : the side that supplies words and consumes bits (upstream/downstream)
//   slave  : the serializer itself
interface word_serializer_if #(
  parameter int W = 8
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in;
  logic         out_valid;
  logic         out_ready;
  logic         out;
  logic         out_last;

  modport master (
    output in_valid, in, out_ready,
    input  in_ready, out_valid, out, out_last
  );

  modport slave (
    input  in_valid, in, out_ready,
    output in_ready, out_valid, out, out_last
  );
endinterface

// File: rtl/word_serializer.sv
// word_serializer
//   Parallel-in / serial-out stage. Takes one W-bit word per input handshake
//   and shifts it out one bit per output handshake, MSB first. A new word can
//   be loaded in the same cycle the final bit of the previous word leaves, so
//   back-to-back words stream at one bit per cycle with no bubble.
// Ports
//   clock_i : clock, all state changes on the rising edge
//   reset_i : synchronous active-high reset
//   bus     : word_serializer_if slave
//             in_valid/in_ready/in          parallel word handshake
//             out_valid/out_ready/out       serial bit handshake
//             out_last                      bit is the LSB of its word
module word_serializer #(
  parameter int W = 8
) (
  input  logic              clock_i,
  input  logic              reset_i,
  word_serializer_if.slave  bus
);

  localparam int CW = $clog2(W + 1);

  // The bit counter doubles as the state: zero means EMPTY, anything else
  // means BUSY with that many bits still to send.
  localparam logic [CW-1:0] CNT_EMPTY = '0;
  localparam logic [CW-1:0] CNT_LAST  = CW'(1);
  localparam logic [CW-1:0] CNT_FULL  = CW'(W);

  logic [W-1:0]  sr_q, sr_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic busy;
  logic in_fire;
  logic out_fire;

  assign busy = (cnt_q != CNT_EMPTY);

  // Outputs are forced low during reset regardless of the register contents,
  // so they are clean even before the first reset edge has landed.
  assign bus.out_valid = !reset_i && busy;
  assign bus.out       = bus.out_valid && sr_q[W-1];
  assign bus.out_last  = !reset_i && (cnt_q == CNT_LAST);

  // Ready when empty, or when the final bit is leaving this very cycle.
  // This is the only combinational input-to-output path (out_ready -> in_ready).
  assign bus.in_ready  = !reset_i &&
                         ((cnt_q == CNT_EMPTY) ||
                          ((cnt_q == CNT_LAST) && bus.out_ready));

  assign in_fire  = bus.in_valid && bus.in_ready;
  assign out_fire = bus.out_valid && bus.out_ready;

  always_comb begin
    sr_d  = sr_q;
    cnt_d = cnt_q;
    if (in_fire) begin
      // Loading wins: it also covers the last bit leaving in the same cycle.
      sr_d  = bus.in;
      cnt_d = CNT_FULL;
    end else if (out_fire) begin
      sr_d  = sr_q << 1;
      cnt_d = cnt_q - CNT_LAST;
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      sr_q  <= '0;
      cnt_q <= CNT_EMPTY;
    end else begin
      sr_q  <= sr_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: tb/tb_word_serializer.sv
// tb_word_serializer
//   Drives a W=8 and a W=1 word_serializer with directed words. A queue model
//   (one entry per bit still owed downstream) predicts every output on every
//   cycle; literal bit sequences and timings pin the model itself.
module tb_word_serializer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  word_serializer_if #(.W(8)) if8 ();
  word_serializer_if #(.W(1)) if1 ();

  word_serializer #(.W(8)) dut8 (.clock_i(clk), .reset_i(rst), .bus(if8.slave));
  word_serializer #(.W(1)) dut1 (.clock_i(clk), .reset_i(rst), .bus(if1.slave));

  int vectors    = 0;
  int miscompares = 0;
  int cyc        = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit q8[$];
  bit q1[$];
  bit in_f8 = 0, out_f8 = 0, in_f1 = 0, out_f1 = 0;
  logic [7:0] word8;
  logic       word1;

  // Bits actually delivered by the DUTs
  bit log8[$];
  bit last8[$];
  bit log1[$];
  int fire_cyc1[$];

  function automatic logic [31:0] pack(input bit q[$]);
    logic [31:0] v = '0;
    foreach (q[i]) v = {v[30:0], q[i]};
    return v;
  endfunction

  // Compare process: outputs checked on the falling edge, away from the
  // active edge; the model's own readiness decides the next edge's fires.
  always @(negedge clk) begin
    bit ir, ov, o, l;
    cyc++;
    // W=8 instance
    ir = !rst && (q8.size() == 0 || (q8.size() == 1 && if8.out_ready));
    ov = !rst && (q8.size() != 0);
    o  = ov && q8[0];
    l  = ov && (q8.size() == 1);
    chk("w8_in_ready",  32'(if8.in_ready),  32'(ir));
    chk("w8_out_valid", 32'(if8.out_valid), 32'(ov));
    chk("w8_out",       32'(if8.out),       32'(o));
    chk("w8_out_last",  32'(if8.out_last),  32'(l));
    in_f8  = ir && if8.in_valid;
    out_f8 = ov && if8.out_ready;
    word8  = if8.in;
    if (if8.out_valid && if8.out_ready) begin
      log8.push_back(if8.out);
      last8.push_back(if8.out_last);
    end
    // W=1 instance
    ir = !rst && (q1.size() == 0 || (q1.size() == 1 && if1.out_ready));
    ov = !rst && (q1.size() != 0);
    o  = ov && q1[0];
    l  = ov && (q1.size() == 1);
    chk("w1_in_ready",  32'(if1.in_ready),  32'(ir));
    chk("w1_out_valid", 32'(if1.out_valid), 32'(ov));
    chk("w1_out",       32'(if1.out),       32'(o));
    chk("w1_out_last",  32'(if1.out_last),  32'(l));
    in_f1  = ir && if1.in_valid;
    out_f1 = ov && if1.out_ready;
    word1  = if1.in;
    if (if1.out_valid && if1.out_ready) begin
      log1.push_back(if1.out);
      fire_cyc1.push_back(cyc);
    end
  end

  always @(posedge clk) begin
    if (rst) begin
      q8.delete();
      q1.delete();
    end else begin
      if (out_f8) void'(q8.pop_front());
      if (in_f8) for (int i = 7; i >= 0; i--) q8.push_back(word8[i]);
      if (out_f1) void'(q1.pop_front());
      if (in_f1) q1.push_back(word1);
    end
  end

  // ---------------- stimulus helpers ----------------
  // Presents a word and holds it until accepted; n = edges waited.
  task automatic send8(input logic [7:0] w, output int n);
    bit fired;
    if8.in_valid = 1'b1;
    if8.in       = w;
    n = 0;
    do begin
      @(negedge clk);
      fired = if8.in_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!fired && n < 60);
    if (!fired) chk("w8_accept_timeout", 32'(n), 32'(0));
  endtask

  task automatic send1(input logic w);
    bit fired;
    int n = 0;
    if1.in_valid = 1'b1;
    if1.in       = w;
    do begin
      @(negedge clk);
      fired = if1.in_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!fired && n < 60);
    if (!fired) chk("w1_accept_timeout", 32'(n), 32'(0));
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // ---------------- directed tests ----------------
  initial begin
    int n;
    logic [7:0] fwd, rev;
    if8.in_valid = 0; if8.in = '0; if8.out_ready = 1;
    if1.in_valid = 0; if1.in = '0; if1.out_ready = 1;
    idle(3);
    rst = 0;
    @(negedge clk);
    chk("reset_in_ready",  32'(if8.in_ready),  32'd1);
    chk("reset_out_valid", 32'(if8.out_valid), 32'd0);
    idle(1);

    // 1: single word A5
    log8.delete(); last8.delete();
    send8(8'hA5, n);
    chk("t1_accept_wait", 32'(n), 32'd1);
    if8.in_valid = 0;
    idle(12);
    chk("t1_bits",   pack(log8),  32'h0000_00A5);
    chk("t1_count",  32'(log8.size()), 32'd8);
    chk("t1_last",   pack(last8), 32'h0000_0001);
    $display("t1: word a5 -> bits %0h", pack(log8));

    // 2: back-to-back A5, 3C
    log8.delete(); last8.delete();
    send8(8'hA5, n);
    send8(8'h3C, n);
    chk("t2_second_accept_wait", 32'(n), 32'd8);
    if8.in_valid = 0;
    idle(12);
    chk("t2_bits",  pack(log8),  32'h0000_A53C);
    chk("t2_last",  pack(last8), 32'h0000_0101);
    $display("t2: words a5,3c -> bits %0h", pack(log8));

    // 3: backpressure with out_ready pattern 1,0,0
    log8.delete(); last8.delete();
    send8(8'hC3, n);
    if8.in_valid = 0;
    for (int i = 0; i < 30; i++) begin
      if8.out_ready = (i % 3 == 0);
      idle(1);
    end
    if8.out_ready = 1;
    idle(2);
    chk("t3_bits",  pack(log8), 32'h0000_00C3);
    chk("t3_count", 32'(log8.size()), 32'd8);
    $display("t3: word c3 stalled -> bits %0h", pack(log8));

    // 4: reset mid-word
    log8.delete(); last8.delete();
    send8(8'hFF, n);
    if8.in_valid = 0;
    idle(3);
    rst = 1;
    idle(1);
    rst = 0;
    @(negedge clk);
    chk("t4_out_valid_after_reset", 32'(if8.out_valid), 32'd0);
    chk("t4_in_ready_after_reset",  32'(if8.in_ready),  32'd1);
    chk("t4_bits_before_reset", pack(log8), 32'h0000_0007);
    @(posedge clk); #1;
    log8.delete();
    send8(8'h01, n);
    if8.in_valid = 0;
    idle(12);
    chk("t4_new_word", pack(log8), 32'h0000_0001);
    chk("t4_count", 32'(log8.size()), 32'd8);
    $display("t4: reset mid ff, then 01 -> bits %0h", pack(log8));

    // 5: W=1 stream 1,0,1
    log1.delete(); fire_cyc1.delete();
    send1(1'b1);
    send1(1'b0);
    send1(1'b1);
    if1.in_valid = 0;
    idle(4);
    chk("t5_bits",  pack(log1), 32'h0000_0005);
    chk("t5_count", 32'(log1.size()), 32'd3);
    if (fire_cyc1.size() == 3)
      chk("t5_no_bubble", 32'(fire_cyc1[2] - fire_cyc1[0]), 32'd2);
    $display("t5: w1 words 1,0,1 -> bits %0h", pack(log1));

    // 6: bit-reversed input gives LSB-first order
    log8.delete();
    fwd = 8'h01;
    for (int i = 0; i < 8; i++) rev[i] = fwd[7-i];
    send8(rev, n);
    if8.in_valid = 0;
    idle(12);
    chk("t6_bits", pack(log8), 32'h0000_0080);
    if (log8.size() > 0) chk("t6_first_bit", 32'(log8[0]), 32'd1);
    $display("t6: reversed 01 -> bits %0h", pack(log8));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Absolute safety net
  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
